code_packer: RTL



---
 rtl/compress_pkg.sv | 26 ++
 rtl/code_encoder.sv | 61 ++++++
 rtl/code_packer.sv | 137 +++++++++++++
 3 files changed

// File: rtl/compress_pkg.sv
// Shared types for the compressed-word code packer: code types, code prefixes
// and packer states.
package compress_pkg;

    typedef enum logic [2:0] {
        CODE_ZZZZ = 3'b000,
        CODE_MMMM = 3'b001,
        CODE_ZZZX = 3'b010,
        CODE_MMMX = 3'b011,
        CODE_MMXX = 3'b100,
        CODE_XXXX = 3'b101
    } code_t;

    localparam logic [1:0] PFX_ZZZZ = 2'b00;
    localparam logic [1:0] PFX_MMMM = 2'b10;
    localparam logic [3:0] PFX_ZZZX = 4'b1101;
    localparam logic [3:0] PFX_MMMX = 4'b1110;
    localparam logic [3:0] PFX_MMXX = 4'b1100;
    localparam logic [1:0] PFX_XXXX = 2'b01;

    typedef enum logic {
        S_RUN   = 1'b0,
        S_FLUSH = 1'b1
    } state_t;

endpackage

// File: rtl/code_encoder.sv
// Combinational encoder: one descriptor to its variable-length code,
// right-aligned in o_code_bits, with its length and an illegal-type flag.
module code_encoder
    import compress_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int DICT_IDX_W = 4,
    localparam int MAX_CODE  = DATA_WIDTH + 2,
    localparam int LEN_W     = $clog2(MAX_CODE + 1)
) (
    input  logic [2:0]            i_code,
    input  logic [DICT_IDX_W-1:0] i_dict_idx,
    input  logic [DATA_WIDTH-1:0] i_word,
    output logic [MAX_CODE-1:0]   o_code_bits,
    output logic [LEN_W-1:0]      o_len,
    output logic                  o_illegal
);

    localparam int Q = DATA_WIDTH / 4;

    if (4 + DICT_IDX_W + 2 * Q > MAX_CODE) begin : g_bad_idx_w
        $error("code_encoder: DICT_IDX_W too wide for the mmxx code to fit in MAX_CODE");
    end

    // NOTE: every output gets a default before the case so no path infers a latch.
    always_comb begin
        o_code_bits = '0;
        o_len       = '0;
        o_illegal   = 1'b0;
        case (i_code)
            CODE_ZZZZ: begin
                o_code_bits = MAX_CODE'(PFX_ZZZZ);
                o_len       = LEN_W'(2);
            end
            CODE_MMMM: begin
                o_code_bits = MAX_CODE'({PFX_MMMM, i_dict_idx});
                o_len       = LEN_W'(2 + DICT_IDX_W);
            end
            CODE_ZZZX: begin
                o_code_bits = MAX_CODE'({PFX_ZZZX, i_word[Q-1:0]});
                o_len       = LEN_W'(4 + Q);
            end
            CODE_MMMX: begin
                o_code_bits = MAX_CODE'({PFX_MMMX, i_dict_idx, i_word[Q-1:0]});
                o_len       = LEN_W'(4 + DICT_IDX_W + Q);
            end
            CODE_MMXX: begin
                o_code_bits = MAX_CODE'({PFX_MMXX, i_dict_idx, i_word[2*Q-1:0]});
                o_len       = LEN_W'(4 + DICT_IDX_W + 2 * Q);
            end
            CODE_XXXX: begin
                o_code_bits = MAX_CODE'({PFX_XXXX, i_word});
                o_len       = LEN_W'(2 + DATA_WIDTH);
            end
            default: begin
                o_illegal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/code_packer.sv
// Packs variable-length codes MSB-first into OUT_WIDTH-bit words with
// valid/ready on both sides; flush emits the padded final partial word.
module code_packer
    import compress_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int DICT_IDX_W = 4,
    parameter int OUT_WIDTH  = 64
) (
    input  logic                           i_clk,
    input  logic                           i_rst,
    input  logic                           i_valid,
    output logic                           o_ready,
    input  logic [2:0]                     i_code,
    input  logic [DICT_IDX_W-1:0]          i_dict_idx,
    input  logic [DATA_WIDTH-1:0]          i_word,
    input  logic                           i_flush,
    output logic                           o_valid,
    input  logic                           i_ready,
    output logic [OUT_WIDTH-1:0]           o_data,
    output logic [$clog2(OUT_WIDTH+1)-1:0] o_bits,
    output logic                           o_last,
    output logic                           o_err
);

    localparam int MAX_CODE = DATA_WIDTH + 2;
    localparam int ACC_W    = OUT_WIDTH + MAX_CODE;
    localparam int FILL_W   = $clog2(ACC_W + 1);
    localparam int LEN_W    = $clog2(MAX_CODE + 1);
    localparam int BITS_W   = $clog2(OUT_WIDTH + 1);

    if (DATA_WIDTH % 4 != 0) begin : g_bad_data_width
        $error("code_packer: DATA_WIDTH must be a multiple of 4");
    end
    if (OUT_WIDTH < DATA_WIDTH + 2) begin : g_bad_out_width
        $error("code_packer: OUT_WIDTH must be at least DATA_WIDTH+2");
    end

    state_t             state_q, state_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [FILL_W-1:0]  fill_q, fill_d;
    logic               err_q, err_d;

    logic [MAX_CODE-1:0] code_bits;
    logic [LEN_W-1:0]    code_len;
    logic                code_illegal;

    logic               full;
    logic               accept;
    logic               emit;
    logic [FILL_W-1:0]  shift_amt;
    logic [ACC_W-1:0]   appended;

    code_encoder #(
        .DATA_WIDTH (DATA_WIDTH),
        .DICT_IDX_W (DICT_IDX_W)
    ) u_encoder (
        .i_code      (i_code),
        .i_dict_idx  (i_dict_idx),
        .i_word      (i_word),
        .o_code_bits (code_bits),
        .o_len       (code_len),
        .o_illegal   (code_illegal)
    );

    // Outputs depend only on registers, so ready never combinationally follows ready.
    always_comb begin
        full    = fill_q >= FILL_W'(OUT_WIDTH);
        o_ready = (state_q == S_RUN) && !full;
        o_valid = full || (state_q == S_FLUSH);
        o_last  = (state_q == S_FLUSH) && !full;
        o_data  = '0;
        o_bits  = '0;
        o_err   = err_q;
        if (full) begin
            o_data = acc_q[ACC_W-1 -: OUT_WIDTH];
            o_bits = BITS_W'(OUT_WIDTH);
        end else if (state_q == S_FLUSH) begin
            // Bits below fill are always zero, so the top slice is already padded.
            o_data = acc_q[ACC_W-1 -: OUT_WIDTH];
            o_bits = BITS_W'(fill_q);
        end
    end

    always_comb begin
        accept    = i_valid && o_ready;
        emit      = o_valid && i_ready;
        shift_amt = FILL_W'(ACC_W) - fill_q - FILL_W'(code_len);
        appended  = ACC_W'(code_bits) << shift_amt;

        state_d = state_q;
        acc_d   = acc_q;
        fill_d  = fill_q;
        err_d   = err_q;

        if (accept) begin
            if (code_illegal) begin
                err_d = 1'b1;
            end else begin
                acc_d  = acc_q | appended;
                fill_d = fill_q + FILL_W'(code_len);
            end
        end

        if (o_ready && i_flush) begin
            state_d = S_FLUSH;
        end

        // Accept and emit never coincide: o_ready and o_valid are exclusive.
        if (emit) begin
            if (o_last) begin
                acc_d   = '0;
                fill_d  = '0;
                state_d = S_RUN;
            end else begin
                acc_d  = acc_q << OUT_WIDTH;
                fill_d = fill_q - FILL_W'(OUT_WIDTH);
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= S_RUN;
            acc_q   <= '0;
            fill_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            fill_q  <= fill_d;
            err_q   <= err_d;
        end
    end

endmodule
